atom_lock_arb: RTL and testbench

Round-robin lock arbiter and owner-gated write port for a shared 8-bit atomic register. Up to NREQ requesters compete for exclusive ownership; only the current owner's writes reach the register, and the owner holds the lock until it releases. An optional watchdog forcibly reclaims a lock held too long. Sits between requesting agents and the shared register, replacing the single-master lock bit with multi-master sequencing.

---
 rtl/atom_lock_arb.sv | 140 ++++++++++++++
 tb/tb_atom_lock_arb.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/atom_lock_arb.sv
// atom_lock_arb: round-robin lock arbiter with owner-gated write port to a shared register.
// Optional forced release of over-long holds when ATOM_ARB_TIMEOUT_EN is defined.
`default_nettype none

module atom_lock_arb #(
    parameter int NREQ    = 4,
    parameter int IW      = 2,
    parameter int DW      = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      rel,
    input  logic [NREQ-1:0]      wr_en,
    input  logic [NREQ*DW-1:0]   wr_data,
    output logic [NREQ-1:0]      gnt,
    output logic [IW-1:0]        owner,
    output logic                 busy,
    output logic [DW-1:0]        reg_q,
    output logic                 tmo
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state, state_d;
    logic [NREQ-1:0] gnt_d;
    logic [IW-1:0]   owner_d;
    logic            busy_d;
    logic [IW-1:0]   ptr, ptr_d;
    logic [DW-1:0]   reg_d;
    logic [IW-1:0]   win;
    logic            found;
    logic            rel_now;
    logic            force_rel;

`ifdef ATOM_ARB_TIMEOUT_EN
    logic [7:0]      cnt, cnt_d;
    logic            tmo_q, tmo_d;

    assign force_rel = (cnt == 8'(TIMEOUT)) && !rel_now;
    assign tmo       = tmo_q;
`else
    assign force_rel = 1'b0;
    assign tmo       = 1'b0;
`endif

    // First requester at or above the pointer, wrapping around
    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin : l_scan
            int idx;
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign rel_now = rel[owner] || !req[owner];

    always_comb begin
        state_d = state;
        gnt_d   = gnt;
        owner_d = owner;
        busy_d  = busy;
        ptr_d   = ptr;
        reg_d   = reg_q;
`ifdef ATOM_ARB_TIMEOUT_EN
        cnt_d   = cnt;
        tmo_d   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_d = HOLD;
                    gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << win;
                    owner_d = win;
                    busy_d  = 1'b1;
`ifdef ATOM_ARB_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            HOLD: begin
                if (wr_en[owner]) begin
                    reg_d = wr_data[int'(owner)*DW +: DW];
                end
`ifdef ATOM_ARB_TIMEOUT_EN
                if (cnt != 8'(TIMEOUT)) begin
                    cnt_d = cnt + 8'd1;
                end
                tmo_d = force_rel;
`endif
                // A same-cycle write still lands; only ownership ends here
                if (rel_now || force_rel) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    ptr_d   = (int'(owner) == NREQ-1) ? '0 : owner + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            gnt   <= '0;
            owner <= '0;
            busy  <= 1'b0;
            ptr   <= '0;
            reg_q <= '0;
`ifdef ATOM_ARB_TIMEOUT_EN
            cnt   <= 8'd0;
            tmo_q <= 1'b0;
`endif
        end else begin
            state <= state_d;
            gnt   <= gnt_d;
            owner <= owner_d;
            busy  <= busy_d;
            ptr   <= ptr_d;
            reg_q <= reg_d;
`ifdef ATOM_ARB_TIMEOUT_EN
            cnt   <= cnt_d;
            tmo_q <= tmo_d;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_atom_lock_arb.sv
// Testbench for atom_lock_arb: scenario tasks checked against a transaction-level lock model.
`default_nettype none

module tb_atom_lock_arb;

    localparam int NREQ = 4;
    localparam int IW   = 2;
    localparam int DW   = 8;
    localparam int TMO  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ-1:0]   rel = '0;
    logic [NREQ-1:0]   wr_en = '0;
    logic [NREQ*DW-1:0] wr_data = '0;
    logic [NREQ-1:0]   gnt;
    logic [IW-1:0]     owner;
    logic              busy;
    logic [DW-1:0]     reg_q;
    logic              tmo;

    int checks = 0;
    int failures = 0;

    // Model: who holds the lock, where the rotation resumes, register contents
    bit  m_busy;
    int  m_owner;
    int  m_ptr;
    int  m_cnt;
    bit  m_tmo;
    logic [DW-1:0] m_reg;

    atom_lock_arb #(.NREQ(NREQ), .IW(IW), .DW(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .rel(rel), .wr_en(wr_en),
        .wr_data(wr_data), .gnt(gnt), .owner(owner), .busy(busy),
        .reg_q(reg_q), .tmo(tmo)
    );

    always #5 clk = ~clk;

    function automatic logic [NREQ-1:0] exp_gnt();
        return m_busy ? NREQ'(1 << m_owner) : '0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_tmo = 0; m_reg = '0;
    endtask

    // Advance the model by one clock using the inputs currently driven, then clock the DUT
    task automatic cycle();
        bit normal, forced;
        if (!m_busy) begin
            m_tmo = 0;
            for (int k = 0; k < NREQ; k++) begin
                if (!m_busy && req[(m_ptr + k) % NREQ]) begin
                    m_busy  = 1;
                    m_owner = (m_ptr + k) % NREQ;
                    m_cnt   = 0;
                end
            end
        end else begin
            if (wr_en[m_owner]) m_reg = wr_data[m_owner*DW +: DW];
            normal = rel[m_owner] || !req[m_owner];
            forced = 0;
`ifdef ATOM_ARB_TIMEOUT_EN
            forced = !normal && (m_cnt == TMO);
`endif
            m_tmo = forced;
            if (normal || forced) begin
                m_busy = 0;
                m_ptr  = (m_owner + 1) % NREQ;
            end else if (m_cnt < TMO) begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; rel = '0; wr_en = '0; wr_data = '0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (gnt !== '0)   begin failures++; $display("FAIL reset_gnt actual=%b required=0", gnt); end
        if (owner !== '0) begin failures++; $display("FAIL reset_owner actual=%0d required=0", owner); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
        if (reg_q !== '0) begin failures++; $display("FAIL reset_reg actual=%h required=00", reg_q); end
        if (tmo !== 1'b0) begin failures++; $display("FAIL reset_tmo actual=%b required=0", tmo); end
    endtask

    task automatic test_first_grant();
        req = 4'b0010;
        cycle();
        checks += 4;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL first_gnt actual=%b required=0010", gnt); end
        if (owner !== 2'd1)  begin failures++; $display("FAIL first_owner actual=%0d required=1", owner); end
        if (busy !== 1'b1)   begin failures++; $display("FAIL first_busy actual=%b required=1", busy); end
        if (reg_q !== 8'h00) begin failures++; $display("FAIL first_reg actual=%h required=00", reg_q); end
    endtask

    task automatic test_write_filter();
        wr_en = 4'b0110;
        wr_data = '0;
        wr_data[1*DW +: DW] = 8'hA5;
        wr_data[2*DW +: DW] = 8'h3C;
        cycle();
        checks++;
        if (reg_q !== 8'hA5) begin failures++; $display("FAIL owner_write actual=%h required=a5", reg_q); end
        wr_en = 4'b0100;
        cycle();
        checks++;
        if (reg_q !== 8'hA5) begin failures++; $display("FAIL nonowner_write actual=%h required=a5", reg_q); end
        wr_en = '0;
        rel = 4'b0100;
        cycle();
        checks++;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL nonowner_rel actual=%b required=0010", gnt); end
        rel = '0;
    endtask

    task automatic test_write_release();
        rel = 4'b0010;
        wr_en = 4'b0010;
        wr_data[1*DW +: DW] = 8'h5A;
        cycle();
        rel = '0; wr_en = '0; req = '0;
        checks += 2;
        if (reg_q !== 8'h5A) begin failures++; $display("FAIL wr_rel_reg actual=%h required=5a", reg_q); end
        if (gnt !== '0)      begin failures++; $display("FAIL wr_rel_gnt actual=%b required=0000", gnt); end
        cycle();
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            cycle();
            checks++;
            if (gnt !== NREQ'(1 << order[n])) begin
                failures++; $display("FAIL rr_grant%0d actual=%b required=%b", n, gnt, NREQ'(1 << order[n]));
            end
            wr_en = NREQ'(1 << order[n]);
            rel   = NREQ'(1 << order[n]);
            wr_data = '0;
            wr_data[order[n]*DW +: DW] = DW'(8'h10 + n);
            cycle();
            wr_en = '0; rel = '0;
            checks += 2;
            if (gnt !== '0) begin failures++; $display("FAIL rr_gap%0d actual=%b required=0000", n, gnt); end
            if (reg_q !== DW'(8'h10 + n)) begin
                failures++; $display("FAIL rr_reg%0d actual=%h required=%h", n, reg_q, DW'(8'h10 + n));
            end
        end
        req = '0;
        cycle();
    endtask

    task automatic test_timeout();
        int held = 0;
        int pulses = 0;
        do_reset();
        req = 4'b0011;
`ifdef ATOM_ARB_TIMEOUT_EN
        for (int n = 0; n < 20 && pulses == 0; n++) begin
            cycle();
            if (gnt == 4'b0001) held++;
            if (tmo) pulses++;
        end
        checks += 3;
        if (pulses != 1) begin failures++; $display("FAIL tmo_pulse actual=%0d required=1", pulses); end
        if (held != TMO + 1) begin failures++; $display("FAIL tmo_hold actual=%0d required=%0d", held, TMO + 1); end
        if (gnt !== '0) begin failures++; $display("FAIL tmo_gap actual=%b required=0000", gnt); end
        cycle();
        checks += 2;
        if (gnt !== 4'b0010) begin failures++; $display("FAIL tmo_next actual=%b required=0010", gnt); end
        if (tmo !== 1'b0) begin failures++; $display("FAIL tmo_once actual=%b required=0", tmo); end
`else
        cycle();
        for (int n = 0; n < 100; n++) begin
            cycle();
            if (gnt == 4'b0001) held++;
            if (tmo) pulses++;
        end
        checks += 2;
        if (held != 100) begin failures++; $display("FAIL hold_kept actual=%0d required=100", held); end
        if (pulses != 0) begin failures++; $display("FAIL tmo_zero actual=%0d required=0", pulses); end
`endif
        req = '0;
        cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            req     = NREQ'($urandom_range(0, 3) == 0 ? $urandom : (req | NREQ'($urandom)));
            rel     = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
            wr_en   = NREQ'($urandom);
            wr_data = {$urandom, $urandom};
            cycle();
            checks += 4;
            if (gnt !== exp_gnt()) begin failures++; $display("FAIL rnd_gnt%0d actual=%b required=%b", n, gnt, exp_gnt()); end
            if (busy !== m_busy)   begin failures++; $display("FAIL rnd_busy%0d actual=%b required=%b", n, busy, m_busy); end
            if (reg_q !== m_reg)   begin failures++; $display("FAIL rnd_reg%0d actual=%h required=%h", n, reg_q, m_reg); end
            if (tmo !== m_tmo)     begin failures++; $display("FAIL rnd_tmo%0d actual=%b required=%b", n, tmo, m_tmo); end
            if (m_busy) begin
                checks++;
                if (owner !== IW'(m_owner)) begin
                    failures++; $display("FAIL rnd_owner%0d actual=%0d required=%0d", n, owner, m_owner);
                end
            end
        end
        req = '0; rel = '0; wr_en = '0;
        cycle();
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        cycle();
        wr_en = 4'b0100;
        wr_data[2*DW +: DW] = 8'hC3;
        cycle();
        wr_en = '0;
        // Drop reset between edges: outputs must clear without a clock
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        checks += 3;
        if (gnt !== '0)    begin failures++; $display("FAIL arst_gnt actual=%b required=0000", gnt); end
        if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy actual=%b required=0", busy); end
        if (reg_q !== '0)  begin failures++; $display("FAIL arst_reg actual=%h required=00", reg_q); end
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_first_grant();
        test_write_filter();
        test_write_release();
        test_round_robin();
        test_timeout();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
